// File: rtl/ccc_pll_ctrl_pkg.sv
// ccc_pll_ctrl_pkg: shared state encoding, APB widths and request record for ccc_pll_ctrl
package ccc_pll_ctrl_pkg;
  localparam int APB_ADDR_W = 6;
  localparam int APB_DATA_W = 8;
  typedef enum logic [2:0] {ARST, WAIT_LOCK, RUN, ERROR, LOST, SETUP, ACCESS} state_e;
  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } req_t;
endpackage

// File: rtl/ccc_lock_monitor.sv
// ccc_lock_monitor: 2-flop LOCK synchroniser plus consecutive-high stable counter
module ccc_lock_monitor #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int CNT_W              = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic ccc_lock,
  input  logic en,
  output logic lock_s,
  output logic lock_stable
);
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] stab_q, stab_d;
  assign lock_s      = sync_q[1];
  assign lock_stable = en && lock_s && (stab_q >= CNT_W'(LOCK_STABLE_CYCLES - 1));
  always_comb begin
    sync_d = {sync_q[0], ccc_lock};
    stab_d = (en && lock_s) ? (lock_stable ? stab_q : stab_q + CNT_W'(1)) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      stab_q <= '0;
    end else begin
      sync_q <= sync_d;
      stab_q <= stab_d;
    end
  end
endmodule

// File: rtl/ccc_pll_ctrl.sv
// ccc_pll_ctrl: CCC/PLL reset-lock sequencer and APB reconfiguration master.
// Define CCC_PLL_CTRL_AUTO_RELOCK_EN to retry via ARST on lock loss or timeout.
module ccc_pll_ctrl
  import ccc_pll_ctrl_pkg::*;
#(
  parameter int ARST_CYCLES         = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int CNT_W               = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ccc_lock,
  input  logic                  ccc_busy,
  input  logic [APB_DATA_W-1:0] ccc_prdata,
  output logic                  pll_arst_n,
  output logic                  ccc_psel,
  output logic                  ccc_penable,
  output logic                  ccc_pwrite,
  output logic [APB_ADDR_W-1:0] ccc_paddr,
  output logic [APB_DATA_W-1:0] ccc_pwdata,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [APB_ADDR_W-1:0] req_addr,
  input  logic [APB_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  input  logic                  relock,
  output logic                  locked,
  output logic                  lock_err,
  output logic                  sys_rst
);
`ifdef CCC_PLL_CTRL_AUTO_RELOCK_EN
  localparam state_e LOSS_ST = ARST;
  localparam state_e TMO_ST  = ARST;
`else
  localparam state_e LOSS_ST = LOST;
  localparam state_e TMO_ST  = ERROR;
`endif
  state_e                state_q, state_d, ret_q, ret_d, home;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pend_q, pend_d, lock_err_q, lock_err_d, rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_W-1:0] rdata_q, rdata_d;
  req_t                  req_q, req_d;
  logic                  lock_s, lock_stable, fire;
  ccc_lock_monitor #(.LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES), .CNT_W(CNT_W)) u_mon (
    .clk(clk), .rst(rst), .ccc_lock(ccc_lock), .en(state_q == WAIT_LOCK),
    .lock_s(lock_s), .lock_stable(lock_stable)
  );
  // during a transfer the visible reset/lock status belongs to the state that launched it
  assign home        = (state_q == SETUP || state_q == ACCESS) ? ret_q : state_q;
  assign pll_arst_n  = home != ARST;
  assign locked      = home == RUN;
  assign sys_rst     = home != RUN;
  assign lock_err    = lock_err_q;
  assign req_ready   = (state_q inside {RUN, ERROR, LOST}) && !ccc_busy && !pend_q;
  assign fire        = req_valid && req_ready;
  assign ccc_psel    = state_q == SETUP || state_q == ACCESS;
  assign ccc_penable = state_q == ACCESS;
  assign ccc_pwrite  = req_q.write;
  assign ccc_paddr   = req_q.addr;
  assign ccc_pwdata  = req_q.wdata;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    lock_err_d  = lock_err_q;
    req_d       = req_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    case (state_q)
      ARST: state_d = (cnt_q == CNT_W'(ARST_CYCLES - 1)) ? WAIT_LOCK : ARST;
      WAIT_LOCK: begin
        if (lock_stable) begin
          state_d    = RUN;
          lock_err_d = 1'b0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          state_d    = TMO_ST;
          lock_err_d = 1'b1;
        end
      end
      RUN, ERROR, LOST: begin
        if (fire) begin
          state_d = SETUP;
          ret_d   = state_q;
          req_d   = {req_write, req_addr, req_wdata};
        end else if (pend_q) state_d = ARST;
        else if (state_q == RUN && !lock_s) state_d = LOSS_ST;
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        state_d     = ret_q;
        rsp_valid_d = 1'b1;
        rdata_d     = req_q.write ? '0 : ccc_prdata;
      end
      default: state_d = ARST;
    endcase
    cnt_d  = (state_d == state_q && (state_q == ARST || state_q == WAIT_LOCK)) ? cnt_q + CNT_W'(1) : '0;
    pend_d = (state_d == ARST || state_q == ARST || state_q == WAIT_LOCK) ? 1'b0 : pend_q | relock;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARST;
      ret_q       <= RUN;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      lock_err_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      req_q       <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      lock_err_q  <= lock_err_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      req_q       <= req_d;
    end
  end
endmodule

// File: tb/tb_ccc_pll_ctrl.sv
// tb_ccc_pll_ctrl: self-checking bench for ccc_pll_ctrl with a register-file CCC model
module tb_ccc_pll_ctrl;
  logic       clk, rst, ccc_lock, ccc_busy, pll_arst_n, ccc_psel, ccc_penable, ccc_pwrite;
  logic [7:0] ccc_prdata, ccc_pwdata, req_wdata, rsp_rdata;
  logic [5:0] ccc_paddr, req_addr;
  logic       req_valid, req_ready, req_write, rsp_valid, relock, locked, lock_err, sys_rst;
  logic [7:0] dev_mem [64];
  logic [7:0] ref_mem [64];
  int n_cmp, n_fail;

  typedef struct { logic w; logic [5:0] a; logic [7:0] d; logic [7:0] rd; } vec_t;
  vec_t vt[7];

  ccc_pll_ctrl #(.ARST_CYCLES(16), .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT_CYCLES(100), .CNT_W(17)) dut (
    .clk(clk), .rst(rst), .ccc_lock(ccc_lock), .ccc_busy(ccc_busy), .ccc_prdata(ccc_prdata),
    .pll_arst_n(pll_arst_n), .ccc_psel(ccc_psel), .ccc_penable(ccc_penable), .ccc_pwrite(ccc_pwrite),
    .ccc_paddr(ccc_paddr), .ccc_pwdata(ccc_pwdata), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .relock(relock), .locked(locked), .lock_err(lock_err), .sys_rst(sys_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CCC register file: written at the end of an APB write access, read combinationally
  assign ccc_prdata = dev_mem[ccc_paddr];
  always @(posedge clk) if (ccc_psel && ccc_penable && ccc_pwrite) dev_mem[ccc_paddr] = ccc_pwdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic arst_pulse(input string tag);
    int n, len;
    n = 0;
    while (pll_arst_n && n < 8) begin tick; n++; end
    chk({tag, " arst start"}, pll_arst_n, 0);
    chk({tag, " arst status"}, {locked, sys_rst}, 2'b01);
    len = 0;
    while (!pll_arst_n && len < 100) begin tick; len++; end
    chk({tag, " arst len"}, len, 16);
  endtask

  task automatic wait_lock(input string tag);
    int n;
    n = 0;
    while (!locked && n < 200) begin tick; n++; end
    chk({tag, " locked"}, {locked, sys_rst}, 2'b10);
  endtask

  task automatic pulse_relock;
    relock = 1'b1;
    tick;
    relock = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic w, input logic [5:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    #1;
    chk({tag, " ready"}, req_ready, 1);
    tick;
    req_valid = 1'b0;
    chk({tag, " setup"}, {ccc_psel, ccc_penable, ccc_pwrite, ccc_paddr, (w ? ccc_pwdata : d)}, {1'b1, 1'b0, w, a, d});
    tick;
    chk({tag, " access"}, {ccc_psel, ccc_penable, rsp_valid}, 3'b110);
    tick;
    chk({tag, " rsp"}, {rsp_valid, ccc_psel, ccc_penable, rsp_rdata}, {3'b100, exp_rd});
    if (w) ref_mem[a] = d;
    tick;
    chk({tag, " rsp drop"}, rsp_valid, 0);
  endtask

  initial begin
    int e, n, k;
    logic saw, exp_ready, acc, s_w;
    logic [5:0] s_a;
    logic [7:0] s_d, exp_rd;
    vt[0] = '{1'b1, 6'h05, 8'hA7, 8'h00};
    vt[1] = '{1'b0, 6'h3F, 8'h00, 8'h5C};
    vt[2] = '{1'b0, 6'h05, 8'h00, 8'hA7};
    vt[3] = '{1'b1, 6'h3F, 8'h11, 8'h00};
    vt[4] = '{1'b0, 6'h3F, 8'h00, 8'h11};
    vt[5] = '{1'b1, 6'h00, 8'hFF, 8'h00};
    vt[6] = '{1'b0, 6'h00, 8'h00, 8'hFF};
    n_cmp = 0; n_fail = 0;
    for (int i = 0; i < 64; i++) begin
      dev_mem[i] = 8'($urandom_range(255));
      ref_mem[i] = dev_mem[i];
    end
    dev_mem[63] = 8'h5C; ref_mem[63] = 8'h5C;
    rst = 1'b1; ccc_lock = 1'b0; ccc_busy = 1'b0; relock = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    tick;
    chk("reset flags", {pll_arst_n, sys_rst, locked, lock_err, req_ready, rsp_valid, ccc_psel, ccc_penable, ccc_pwrite}, 9'b010000000);
    chk("reset bus", {ccc_paddr, ccc_pwdata, rsp_rdata}, 0);
    tick;
    rst = 1'b0;
    // power-up: lock rises 30 cycles after reset, locked expected 2 sync + 8 stable cycles later
    arst_pulse("powerup");
    e = 16;
    while (e < 30) begin tick; e++; end
    ccc_lock = 1'b1;
    while (!locked && e < 200) begin tick; e++; end
    chk("powerup lock time", (e >= 39 && e <= 41) ? 40 : e, 40);
    chk("powerup status", {locked, sys_rst, lock_err, pll_arst_n}, 4'b1001);

    foreach (vt[i]) do_req($sformatf("vec%0d", i), vt[i].w, vt[i].a, vt[i].d, vt[i].rd);

    ccc_busy = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 6'h3F;
    #1;
    chk("busy ready", req_ready, 0);
    saw = 1'b0;
    repeat (4) begin tick; if (ccc_psel) saw = 1'b1; end
    chk("busy no psel", saw, 0);
    req_valid = 1'b0; ccc_busy = 1'b0;
    tick;

    // random traffic against a latency/register-file model
    k = 9; exp_rd = '0; s_w = 1'b0; s_a = '0; s_d = '0;
    for (int i = 0; i < 400; i++) begin
      ccc_busy  = ($urandom_range(3) == 0);
      req_valid = ($urandom_range(1) == 1);
      req_write = 1'($urandom_range(1));
      req_addr  = 6'($urandom_range(63));
      req_wdata = 8'($urandom_range(255));
      @(negedge clk);
      exp_ready = !ccc_busy && !(k == 1 || k == 2);
      chk("rnd ready", req_ready, exp_ready);
      chk("rnd psel/penable", {ccc_psel, ccc_penable}, {k == 1 || k == 2, k == 2});
      chk("rnd rsp_valid", rsp_valid, k == 3);
      if (k == 1 || k == 2) begin
        chk("rnd apb addr", {ccc_pwrite, ccc_paddr}, {s_w, s_a});
        if (s_w) chk("rnd pwdata", ccc_pwdata, s_d);
      end
      if (k == 3) chk("rnd rdata", rsp_rdata, exp_rd);
      acc = req_valid && exp_ready;
      if (acc) begin
        s_w = req_write; s_a = req_addr; s_d = req_wdata;
        exp_rd = req_write ? 8'h00 : ref_mem[req_addr];
        if (req_write) ref_mem[req_addr] = req_wdata;
      end
      @(posedge clk);
      #1;
      k = acc ? 1 : (k < 9 ? k + 1 : k);
    end
    req_valid = 1'b0; ccc_busy = 1'b0;
    repeat (4) tick;
    chk("rnd still locked", locked, 1);

    // lock glitch of 3 cycles
    ccc_lock = 1'b0;
    repeat (3) tick;
    ccc_lock = 1'b1;
    chk("glitch drop", {locked, sys_rst}, 2'b01);
`ifdef CCC_PLL_CTRL_AUTO_RELOCK_EN
    arst_pulse("glitch auto");
`else
    repeat (30) tick;
    chk("lost holds", {locked, sys_rst, pll_arst_n}, 3'b011);
    do_req("lost req", 1'b0, 6'h3F, 8'h00, ref_mem[63]);
    chk("lost after req", locked, 0);
    pulse_relock;
    arst_pulse("lost relock");
`endif
    wait_lock("glitch");

    // relock collides with a request: transfer first, then ARST
    relock = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 6'h2A; req_wdata = 8'h3C;
    #1;
    chk("col ready", req_ready, 1);
    tick;
    relock = 1'b0; req_valid = 1'b0; ref_mem[42] = 8'h3C;
    chk("col setup", {ccc_psel, ccc_penable}, 2'b10);
    tick;
    chk("col access", {ccc_psel, ccc_penable}, 2'b11);
    tick;
    chk("col rsp", {rsp_valid, rsp_rdata, locked, req_ready}, {1'b1, 8'h00, 1'b1, 1'b0});
    arst_pulse("col");
    wait_lock("col");
    chk("col mem", dev_mem[42], 8'h3C);

    // lock timeout
    ccc_lock = 1'b0;
`ifndef CCC_PLL_CTRL_AUTO_RELOCK_EN
    repeat (3) tick;
    pulse_relock;
`endif
    arst_pulse("tmo");
    n = 0;
    while (!lock_err && n < 300) begin tick; n++; end
    chk("tmo cycles", n, 100);
    chk("tmo status", {lock_err, sys_rst, locked}, 3'b110);
`ifdef CCC_PLL_CTRL_AUTO_RELOCK_EN
    chk("tmo retry arst", pll_arst_n, 0);
    ccc_lock = 1'b1;
    arst_pulse("tmo retry");
`else
    repeat (20) tick;
    chk("error holds", {pll_arst_n, lock_err, sys_rst}, 3'b111);
    do_req("error req", 1'b1, 6'h10, 8'h66, 8'h00);
    chk("error mem", dev_mem[16], 8'h66);
    ccc_lock = 1'b1;
    pulse_relock;
    arst_pulse("error relock");
`endif
    wait_lock("tmo recover");
    chk("lock_err cleared", lock_err, 0);

    // reset in the middle of an access
    req_valid = 1'b1; req_write = 1'b0; req_addr = 6'h3F;
    tick;
    req_valid = 1'b0;
    tick;
    chk("pre-rst access", {ccc_psel, ccc_penable}, 2'b11);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst abandon", {ccc_psel, ccc_penable, rsp_valid, locked, sys_rst}, 5'b00001);
    saw = 1'b0;
    repeat (5) begin tick; if (rsp_valid || ccc_psel) saw = 1'b1; end
    chk("rst no rsp", saw, 0);
    chk("rst restart", pll_arst_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
